// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divider helper.
// Imported by the receiver and by the matching transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic int clks_per_bit(input int frq, input int baud);
        return frq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous receive pin plus a falling-edge
// detector on the synchronised level; all flops reset to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_meta;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, one-cycle strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on the synchronised input
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | sample eight data bits at mid-bit, LSB first
// PARITY | sample the even-parity bit (parity build only)
// STOP   | sample the stop bit, issue valid or error strobes, back to IDLE
module uart_recv
    import uart_pkg::*;
#(
    parameter int P_CLK_FRQ = 48_000_000,
    parameter int P_BAURATE = 9600
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   UART_RX,
    output logic [UART_DATA_W-1:0] RX_DATA,
    output logic                   RX_VALID,
    output logic                   FRAME_ERR,
    output logic                   PARITY_ERR
);

    localparam int CLKS_PER_BIT = clks_per_bit(P_CLK_FRQ, P_BAURATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_W);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_W - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_divider
        $error("uart_recv: CLKS_PER_BIT must be at least 4");
    end

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (CLK),
        .reset   (RESET),
        .rx      (UART_RX),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    uart_state_t            state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [IDX_W-1:0]       idx_q, idx_nxt;
    logic [UART_DATA_W-1:0] shift_q, shift_nxt;
    logic [UART_DATA_W-1:0] data_q, data_nxt;
    logic                   valid_q, valid_nxt;
    logic                   ferr_q, ferr_nxt;
    logic                   par_bad;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_nxt;
    logic                   perr_q, perr_nxt;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        shift_nxt = shift_q;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_q;
        perr_nxt  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_nxt          = '0;
                    shift_nxt[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_s;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                if (cnt_q == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    ferr_nxt  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_nxt  = par_bad;
`endif
                    if (rx_s && !par_bad) begin
                        valid_nxt = 1'b1;
                        data_nxt  = shift_q;
                    end
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            shift_q <= shift_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_nxt;
            perr_q  <= perr_nxt;
`endif
        end
    end

    assign RX_DATA   = data_q;
    assign RX_VALID  = valid_q;
    assign FRAME_ERR = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver, 8N1, LSB first; the receive-side counterpart of the UART_SEND transmitter.
- Synchronises the asynchronous UART_RX pin and samples each bit at mid-bit using a divider derived from P_CLK_FRQ/P_BAURATE.
- Emits each good byte with a one-cycle valid strobe.
- Sits beside UART_SEND under TOP; RX_DATA may drive LED in place of DATA_GEN.

Parameters:
- P_CLK_FRQ, 48_000_000, system clock frequency in Hz
- P_BAURATE, 9600, line baud rate in bit/s

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- UART_RX  input  1  asynchronous serial line; idles high
- RX_DATA  output  8  last correctly received byte; held until the next good byte
- RX_VALID  output  1  one-cycle pulse; RX_DATA updated on the same cycle
- FRAME_ERR  output  1  one-cycle pulse; stop bit sampled low
- PARITY_ERR  output  1  one-cycle pulse; parity mismatch (see Optional Feature)

Behaviour:
- Constants:
  - CLKS_PER_BIT = P_CLK_FRQ / P_BAURATE, integer division, truncated.
  - HALF_BIT = CLKS_PER_BIT / 2.
  - Elaboration error if CLKS_PER_BIT < 4.
  - Bit counter is $clog2(CLKS_PER_BIT) bits wide.
- Input synchroniser:
  - Two flip-flops on UART_RX, both reset to 1, giving rx_s.
  - A third flip-flop holds rx_s delayed one cycle, for edge detection.
- Reset (sync, RESET=1 at a CLK edge):
  - RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, PARITY_ERR=0.
  - State=IDLE, counters=0, synchroniser=1.
  - Reset mid-frame aborts the frame; no strobe is issued.
- States:
  - IDLE:
    - Wait for a falling edge on rx_s (previous 1, current 0).
    - On edge: go to START, clear the clock counter.
    - A line held low with no preceding high is never taken as a start.
  - START:
    - Count to HALF_BIT-1, then sample rx_s.
    - Sample 0: go to DATA, clear the clock counter and bit index.
    - Sample 1: treat as a glitch, return to IDLE, no strobe.
  - DATA:
    - Every CLKS_PER_BIT cycles, sample rx_s into shift-register bit [index]; LSB first.
    - After index 7, go to STOP; with UART_RX_PARITY_EN, go to PARITY instead.
  - PARITY (only with UART_RX_PARITY_EN):
    - After CLKS_PER_BIT cycles, sample the parity bit, then go to STOP.
  - STOP:
    - After CLKS_PER_BIT cycles, sample rx_s and return to IDLE on the next cycle.
    - Stop sampled 1 with no parity error: RX_DATA <= shift register, RX_VALID=1 for one cycle.
    - Stop sampled 0: FRAME_ERR=1 for one cycle; RX_DATA unchanged.
- Return to IDLE at mid-stop allows back-to-back frames with a single stop bit.
- Latency:
  - RX_VALID is asserted 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the first CLK edge that registers UART_RX low.
  - Add CLKS_PER_BIT when parity is enabled.
- Simultaneous errors: FRAME_ERR and PARITY_ERR may pulse together; RX_VALID is never asserted in the same cycle as either.
- No backpressure: the consumer must take RX_DATA on RX_VALID; it is overwritten only by the next good byte.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Expects one even-parity bit between D7 and the stop bit.
  - Mismatch: PARITY_ERR pulses in the STOP-sample cycle and RX_VALID is suppressed.
- Undefined:
  - No PARITY state; plain 8N1.
  - PARITY_ERR is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Function clks_per_bit(frq, baud).
  - Constant UART_DATA_W = 8.
  - UART_SEND is to import the same package.
- One sub-module, uart_rx_sync: two-flip-flop synchroniser plus a falling-edge detector. Outputs rx_s and rx_fall.

Test Plan:
- All scenarios use P_CLK_FRQ=1_600_000, P_BAURATE=100_000, so CLKS_PER_BIT=16.
- Send 8'hA5 as 8N1 at exactly 16 clocks/bit -> one RX_VALID pulse at cycle 2+8+144=154 after the start edge; RX_DATA=8'hA5; FRAME_ERR=0.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with a single stop bit each -> three RX_VALID pulses, 160 cycles apart; data in that order.
- Send a 5-cycle low glitch on an idle line -> no strobe; state back in IDLE; the next frame 8'h81 is received correctly.
- Send 8'h5A with the stop bit forced low -> FRAME_ERR pulse; no RX_VALID; RX_DATA keeps its previous value 8'h81.
- Assert RESET mid-DATA after 4 bits -> outputs reset to 0; no strobe; a following 8'hC3 frame is received correctly.
- With UART_RX_PARITY_EN: send 8'h07 with parity=1 -> RX_VALID, RX_DATA=8'h07. Repeat with parity=0 -> PARITY_ERR pulse; no RX_VALID.
